// File: rtl/weight_rdbuf.sv
// ---------------------------------------------------------------------------
// weight_rdbuf
//
// Purpose
//   Sits behind the weight BRAM address generator. The bank chip-enables are
//   issued together with the read address, while the read data returns RD_LAT
//   cycles later. This block delays the enables so that they line up with the
//   data. It then captures bursts of DEPTH beats from bank pair A (banks 0/1)
//   or bank pair B (banks 2/3) into one of two ping-pong slots.
//
//   The upstream address walks downward, so a slot fills from entry DEPTH-1
//   down to entry 0. A full slot is drained to the PE array as a valid/ready
//   stream in ascending entry order. The BRAM side cannot be stalled: a beat
//   that arrives while its target slot is still full is dropped, and the
//   sticky ovf flag is raised.
//
// Parameters
//   DW      width of one BRAM read port
//   DEPTH   beats per burst and entries per slot (power of 2, >= 2)
//   RD_LAT  BRAM read latency in cycles (>= 1)
//
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset
//   bce0..bce3  bank chip-enables, as issued with the read address
//   brdata0..3  bank read data, valid RD_LAT cycles after the matching bce
//   w_valid     stream beat valid
//   w_ready     PE array accepts the beat when w_valid && w_ready
//   w_data      beat: pair A = {brdata1, brdata0}, pair B = {brdata3, brdata2}
//   w_last      high on entry DEPTH-1 of the slot being drained
//   ovf         sticky: a beat was dropped because its target slot was full
//   pair_err    sticky: aligned enables of pair A and pair B overlapped
// ---------------------------------------------------------------------------
module weight_rdbuf #(
    parameter int DW     = 64,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bce0,
    input  logic              bce1,
    input  logic              bce2,
    input  logic              bce3,
    input  logic [DW-1:0]     brdata0,
    input  logic [DW-1:0]     brdata1,
    input  logic [DW-1:0]     brdata2,
    input  logic [DW-1:0]     brdata3,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [2*DW-1:0]   w_data,
    output logic              w_last,
    output logic              ovf,
    output logic              pair_err
);

    localparam int CW = $clog2(DEPTH);
    localparam int AW = CW + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Enable alignment
    // -----------------------------------------------------------------------
    logic [RD_LAT-1:0] bce_a_sr_q, bce_a_sr_d;
    logic [RD_LAT-1:0] bce_b_sr_q, bce_b_sr_d;
    logic              bce_a_al;
    logic              bce_b_al;

    // -----------------------------------------------------------------------
    // Capture side state
    // -----------------------------------------------------------------------
    logic              wr_slot_q, wr_slot_d;
    logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
    logic [1:0]        full_q, full_d;
    logic              ovf_q, ovf_d;
    logic              pair_err_q, pair_err_d;

    logic              beat_vld;
    logic [2*DW-1:0]   beat_data;
    logic              wr_full;
    logic              beat_accept;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;

    // -----------------------------------------------------------------------
    // Drain side state
    // -----------------------------------------------------------------------
    state_t            state_q, state_d;
    logic              rd_slot_q, rd_slot_d;
    logic [CW-1:0]     rd_idx_q, rd_idx_d;
    logic [CW-1:0]     rd_idx_inc;
    logic              w_valid_q, w_valid_d;
    logic              w_last_q, w_last_d;
    logic [2*DW-1:0]   w_data_q, w_data_d;
    logic              slot_free;

    // Both slots live in one array: address bit CW selects the slot.
    logic [2*DW-1:0]   mem_q [2*DEPTH];

    // The enables are ORed per pair and pushed through RD_LAT flops. The
    // oldest stage is the enable that belongs to the data on brdata* now.
    always_comb begin
        bce_a_sr_d    = bce_a_sr_q;
        bce_b_sr_d    = bce_b_sr_q;
        bce_a_sr_d[0] = bce0 | bce1;
        bce_b_sr_d[0] = bce2 | bce3;
        for (int i = 1; i < RD_LAT; i++) begin
            bce_a_sr_d[i] = bce_a_sr_q[i-1];
            bce_b_sr_d[i] = bce_b_sr_q[i-1];
        end
    end

    assign bce_a_al = bce_a_sr_q[RD_LAT-1];
    assign bce_b_al = bce_b_sr_q[RD_LAT-1];

    // Drain FSM. IDLE waits for the read slot to be full. STREAM presents one
    // registered entry at a time and advances only on a handshake. On the
    // final handshake the slot is released, and the FSM moves straight to
    // the other slot if that one is already full, so no bubble appears.
    assign rd_idx_inc = rd_idx_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        rd_slot_d = rd_slot_q;
        rd_idx_d  = rd_idx_q;
        w_valid_d = w_valid_q;
        w_last_d  = w_last_q;
        w_data_d  = w_data_q;
        slot_free = 1'b0;

        case (state_q)
            IDLE: begin
                if (full_q[rd_slot_q]) begin
                    state_d   = STREAM;
                    w_valid_d = 1'b1;
                    rd_idx_d  = '0;
                    w_data_d  = mem_q[{rd_slot_q, {CW{1'b0}}}];
                    w_last_d  = 1'b0;
                end
            end

            STREAM: begin
                if (w_ready) begin
                    if (w_last_q) begin
                        slot_free = 1'b1;
                        rd_slot_d = ~rd_slot_q;
                        rd_idx_d  = '0;
                        w_last_d  = 1'b0;
                        if (full_q[~rd_slot_q]) begin
                            state_d   = STREAM;
                            w_valid_d = 1'b1;
                            w_data_d  = mem_q[{~rd_slot_q, {CW{1'b0}}}];
                        end else begin
                            state_d   = IDLE;
                            w_valid_d = 1'b0;
                        end
                    end else begin
                        rd_idx_d = rd_idx_inc;
                        w_data_d = mem_q[{rd_slot_q, rd_idx_inc}];
                        w_last_d = (rd_idx_inc == CW'(DEPTH - 1));
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                w_valid_d = 1'b0;
                w_last_d  = 1'b0;
            end
        endcase
    end

    // Capture path. Pair A has priority when both aligned enables are high.
    // A slot released by the drain in this same cycle counts as free for an
    // arriving beat, so no false overflow occurs. The write entry is
    // DEPTH-1-count, which is the bitwise inverse of the count because DEPTH
    // is a power of two. Dropped beats leave the count unchanged.
    always_comb begin
        beat_vld    = bce_a_al | bce_b_al;
        beat_data   = bce_a_al ? {brdata1, brdata0} : {brdata3, brdata2};
        wr_full     = full_q[wr_slot_q] && !(slot_free && (rd_slot_q == wr_slot_q));
        beat_accept = beat_vld && !wr_full;
        mem_we      = beat_accept;
        mem_waddr   = {wr_slot_q, ~wr_cnt_q};

        wr_slot_d   = wr_slot_q;
        wr_cnt_d    = wr_cnt_q;
        full_d      = full_q;
        ovf_d       = ovf_q;
        pair_err_d  = pair_err_q;

        if (slot_free) begin
            full_d[rd_slot_q] = 1'b0;
        end

        if (bce_a_al && bce_b_al) begin
            pair_err_d = 1'b1;
        end

        if (beat_vld && wr_full) begin
            ovf_d = 1'b1;
        end

        if (beat_accept) begin
            wr_cnt_d = wr_cnt_q + CW'(1);
            if (wr_cnt_q == CW'(DEPTH - 1)) begin
                full_d[wr_slot_q] = 1'b1;
                wr_slot_d         = ~wr_slot_q;
            end
        end
    end

    // Control and output registers. Reset discards any partial slot at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bce_a_sr_q <= '0;
            bce_b_sr_q <= '0;
            wr_slot_q  <= 1'b0;
            wr_cnt_q   <= '0;
            full_q     <= '0;
            ovf_q      <= 1'b0;
            pair_err_q <= 1'b0;
            state_q    <= IDLE;
            rd_slot_q  <= 1'b0;
            rd_idx_q   <= '0;
            w_valid_q  <= 1'b0;
            w_last_q   <= 1'b0;
            w_data_q   <= '0;
        end else begin
            bce_a_sr_q <= bce_a_sr_d;
            bce_b_sr_q <= bce_b_sr_d;
            wr_slot_q  <= wr_slot_d;
            wr_cnt_q   <= wr_cnt_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            pair_err_q <= pair_err_d;
            state_q    <= state_d;
            rd_slot_q  <= rd_slot_d;
            rd_idx_q   <= rd_idx_d;
            w_valid_q  <= w_valid_d;
            w_last_q   <= w_last_d;
            w_data_q   <= w_data_d;
        end
    end

    // The storage array has no reset. Entries are read only after their
    // slot has been marked full, so stale contents are never presented.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= beat_data;
        end
    end

    assign w_valid  = w_valid_q;
    assign w_last   = w_last_q;
    assign w_data   = w_data_q;
    assign ovf      = ovf_q;
    assign pair_err = pair_err_q;

endmodule

// File: tb/tb_weight_rdbuf.sv
// ---------------------------------------------------------------------------
// tb_weight_rdbuf
//
// Drives directed bursts into weight_rdbuf. For every beat that the buffer
// should stream out, the stimulus side pushes the expected {last, data} onto
// a queue. A separate monitor pops one entry per handshake and compares it.
// The monitor also checks that w_data/w_last hold during stalls, and that no
// bubble appears between back-to-back slots.
// ---------------------------------------------------------------------------
module tb_weight_rdbuf;

    localparam int DW     = 64;
    localparam int DEPTH  = 32;
    localparam int RD_LAT = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              bce0, bce1, bce2, bce3;
    logic [DW-1:0]     brdata0, brdata1, brdata2, brdata3;
    logic              w_valid;
    logic              w_ready;
    logic [2*DW-1:0]   w_data;
    logic              w_last;
    logic              ovf;
    logic              pair_err;

    int                compared   = 0;
    int                mismatched = 0;

    logic [2*DW:0]     exp_q [$];

    // 0: hold w_ready low, 1: hold it high, 2: random at 50%
    int                ready_mode = 1;
    bit                bubble_chk = 1'b0;

    logic [DW-1:0]     pend0, pend1, pend2, pend3;

    always #5 clk = ~clk;

    weight_rdbuf #(
        .DW     (DW),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bce0     (bce0),
        .bce1     (bce1),
        .bce2     (bce2),
        .bce3     (bce3),
        .brdata0  (brdata0),
        .brdata1  (brdata1),
        .brdata2  (brdata2),
        .brdata3  (brdata3),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_data   (w_data),
        .w_last   (w_last),
        .ovf      (ovf),
        .pair_err (pair_err)
    );

    task automatic checkOutput(input string name, input logic [2*DW:0] act, input logic [2*DW:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Advance one cycle. The enables given here take effect now. The data
    // given here appears on brdata* one cycle later (RD_LAT = 1).
    task automatic applyStimulus(input logic [3:0] bv,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                 input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        @(posedge clk);
        #1;
        brdata0 = pend0;
        brdata1 = pend1;
        brdata2 = pend2;
        brdata3 = pend3;
        {bce3, bce2, bce1, bce0} = bv;
        pend0 = d0;
        pend1 = d1;
        pend2 = d2;
        pend3 = d3;
    endtask

    task automatic idleCycle();
        applyStimulus(4'b0000, '0, '0, '0, '0);
    endtask

    // Burst of nbeats: beat k carries lo=base+k and hi=base+k+100 on the
    // selected pair. The other pair carries decoy values. Beat k lands in
    // entry DEPTH-1-k, so the stream order is k = nbeats-1 down to 0, and
    // w_last is set on k = 0.
    task automatic sendBurst(input bit pair_b, input int base, input int nbeats,
                             input bit push, input int gap_every, input bit err_first);
        logic [DW-1:0] lo, hi;
        logic [3:0]    bv;
        logic [DW-1:0] d0, d1, d2, d3;
        for (int k = 0; k < nbeats; k++) begin
            lo = DW'(base + k);
            hi = DW'(base + k + 100);
            if (!pair_b) begin
                bv = (k % 2 == 0) ? 4'b0001 : 4'b0010;
                d0 = lo;  d1 = hi;  d2 = ~lo; d3 = ~hi;
            end else begin
                bv = (k % 2 == 0) ? 4'b0100 : 4'b1000;
                d0 = ~lo; d1 = ~hi; d2 = lo;  d3 = hi;
            end
            if (err_first && k == 0) begin
                bv = bv | 4'b0100;
                d2 = 64'hdead_dead_dead_dead;
                d3 = 64'hbeef_beef_beef_beef;
            end
            applyStimulus(bv, d0, d1, d2, d3);
            if (gap_every > 0 && (k % gap_every) == gap_every - 1) begin
                idleCycle();
                idleCycle();
            end
        end
        if (push) begin
            for (int k = nbeats - 1; k >= 0; k--) begin
                exp_q.push_back({(k == 0), DW'(base + k + 100), DW'(base + k)});
            end
        end
    endtask

    task automatic waitDrain(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            idleCycle();
            n++;
        end
        checkOutput("drain_done", (2*DW+1)'(exp_q.size()), '0);
        exp_q.delete();
        for (int i = 0; i < 4; i++) idleCycle();
    endtask

    // Only this process drives w_ready.
    initial begin
        w_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       w_ready = 1'b0;
                1:       w_ready = 1'b1;
                default: w_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic          prev_stall = 1'b0;
        logic          must_valid = 1'b0;
        logic [2*DW:0] prev_beat  = '0;
        logic [2*DW:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                must_valid = 1'b0;
            end else begin
                if (must_valid) begin
                    checkOutput("no_bubble", (2*DW+1)'(w_valid), (2*DW+1)'(1));
                end
                must_valid = 1'b0;
                if (prev_stall) begin
                    checkOutput("stall_valid", (2*DW+1)'(w_valid), (2*DW+1)'(1));
                    checkOutput("stall_hold", {w_last, w_data}, prev_beat);
                end
                if (w_valid && w_ready) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL extra_beat: got %h, want no beat", {w_last, w_data});
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("beat", {w_last, w_data}, e);
                        if (bubble_chk && w_last && exp_q.size() > 0) must_valid = 1'b1;
                    end
                end
                prev_stall = w_valid && !w_ready;
                prev_beat  = {w_last, w_data};
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_w_valid"},  (2*DW+1)'(w_valid),  '0);
        checkOutput({tag, "_w_last"},   (2*DW+1)'(w_last),   '0);
        checkOutput({tag, "_w_data"},   (2*DW+1)'(w_data),   '0);
        checkOutput({tag, "_ovf"},      (2*DW+1)'(ovf),      '0);
        checkOutput({tag, "_pair_err"}, (2*DW+1)'(pair_err), '0);
    endtask

    initial begin
        rst_n = 1'b0;
        {bce3, bce2, bce1, bce0} = 4'b0000;
        brdata0 = '0; brdata1 = '0; brdata2 = '0; brdata3 = '0;
        pend0 = '0; pend1 = '0; pend2 = '0; pend3 = '0;
        #1;
        checkResetOutputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idleCycle();

        // One pair-A burst, w_ready held high
        $display("[TB] single pair-A burst");
        ready_mode = 1;
        sendBurst(1'b0, 0, DEPTH, 1'b1, 0, 1'b0);
        waitDrain(200);
        checkOutput("single_ovf", (2*DW+1)'(ovf), '0);
        checkOutput("single_pair_err", (2*DW+1)'(pair_err), '0);

        // Back-to-back A then B, no idle cycle between slots
        $display("[TB] back-to-back A then B");
        bubble_chk = 1'b1;
        sendBurst(1'b0, 200, DEPTH, 1'b1, 0, 1'b0);
        sendBurst(1'b1, 400, DEPTH, 1'b1, 0, 1'b0);
        waitDrain(300);
        bubble_chk = 1'b0;
        checkOutput("b2b_ovf", (2*DW+1)'(ovf), '0);

        // Random ready, with enable gaps inside the first burst
        $display("[TB] random w_ready");
        ready_mode = 2;
        sendBurst(1'b0, 1000, DEPTH, 1'b1, 5, 1'b0);
        sendBurst(1'b1, 2000, DEPTH, 1'b1, 0, 1'b0);
        waitDrain(3000);
        ready_mode = 1;
        checkOutput("rand_ovf", (2*DW+1)'(ovf), '0);

        // Overlapping pair enables on the first beat
        $display("[TB] pair overlap");
        sendBurst(1'b0, 3000, DEPTH, 1'b1, 0, 1'b1);
        waitDrain(200);
        checkOutput("pair_err_set", (2*DW+1)'(pair_err), (2*DW+1)'(1));
        checkOutput("pair_ovf", (2*DW+1)'(ovf), '0);

        // Three bursts with w_ready low: the third is dropped entirely
        $display("[TB] overflow");
        ready_mode = 0;
        sendBurst(1'b0, 4000, DEPTH, 1'b1, 0, 1'b0);
        sendBurst(1'b1, 5000, DEPTH, 1'b1, 0, 1'b0);
        checkOutput("ovf_before_third", (2*DW+1)'(ovf), '0);
        sendBurst(1'b0, 6000, DEPTH, 1'b0, 0, 1'b0);
        idleCycle();
        idleCycle();
        checkOutput("ovf_set", (2*DW+1)'(ovf), (2*DW+1)'(1));
        checkOutput("ovf_valid_held", (2*DW+1)'(w_valid), (2*DW+1)'(1));
        ready_mode = 1;
        waitDrain(400);
        for (int i = 0; i < 10; i++) idleCycle();
        checkOutput("ovf_drained_idle", (2*DW+1)'(w_valid), '0);
        checkOutput("ovf_sticky", (2*DW+1)'(ovf), (2*DW+1)'(1));

        // Reset at beat 17 of a burst, then a clean burst
        $display("[TB] reset mid-burst");
        sendBurst(1'b0, 7000, 17, 1'b0, 0, 1'b0);
        rst_n = 1'b0;
        {bce3, bce2, bce1, bce0} = 4'b0000;
        pend0 = '0; pend1 = '0; pend2 = '0; pend3 = '0;
        brdata0 = '0; brdata1 = '0; brdata2 = '0; brdata3 = '0;
        @(posedge clk);
        #1;
        checkResetOutputs("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idleCycle();
        sendBurst(1'b1, 8000, DEPTH, 1'b1, 0, 1'b0);
        waitDrain(200);
        checkOutput("post_rst_ovf", (2*DW+1)'(ovf), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
